// File: rtl/hazard_ctrl.sv
// Hazard/interlock controller for the IF/DE/MW pipeline: load-latency hold, MDU scoreboard,
// N-source forwarding. Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module hazard_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LD_LAT  = 1,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_de,
  input  logic [NUM_SRC*REG_AW-1:0] rs_de,
  input  logic [NUM_SRC-1:0]        rs_used_de,
  input  logic [REG_AW-1:0]         rd_de,
  input  logic                      rf_en_de,
  input  logic [1:0]                sel_wb_de,
  input  logic                      mdu_de,
  input  logic [REG_AW-1:0]         rd_mw,
  input  logic                      rf_en_mw,
  input  logic                      br_taken,
  output logic [2*NUM_SRC-1:0]      forward,
  output logic                      stall_if,
  output logic                      stall_de,
  output logic                      flush_de,
  output logic                      mdu_busy,
  output logic                      mdu_wb_valid,
  output logic [REG_AW-1:0]         mdu_wb_rd,
  output logic [CNT_W-1:0]          perf_stall_cnt,
  output logic [CNT_W-1:0]          perf_flush_cnt
);

  localparam int MAX_LAT = (LD_LAT > MDU_LAT) ? LD_LAT : MDU_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] LD_INIT  = CW'(LD_LAT);
  localparam logic [CW-1:0] MDU_INIT = CW'(MDU_LAT);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [1:0]    SEL_LOAD = 2'b01;

  logic [CW-1:0]     ld_cnt;
  logic [CW-1:0]     mdu_cnt;
  logic [REG_AW-1:0] ld_rd;
  logic [REG_AW-1:0] mdu_rd;

  logic ld_raw;
  logic mdu_raw;
  logic mdu_waw;
  logic mw_busy;
  logic load_use;
  logic mdu_pend;
  logic mdu_haz;
  logic issue;

  // x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - ONE;
  endfunction

  always_comb begin
    ld_raw  = 1'b0;
    mdu_raw = 1'b0;
    forward = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rs_used_de[k] && reg_hit(rs_de[k*REG_AW +: REG_AW], ld_rd))
        ld_raw = 1'b1;
      if (rs_used_de[k] && reg_hit(rs_de[k*REG_AW +: REG_AW], mdu_rd))
        mdu_raw = 1'b1;
      if (rf_en_mw && reg_hit(rs_de[k*REG_AW +: REG_AW], rd_mw))
        forward[2*k +: 2] = 2'b10;
      else if (mdu_wb_valid && reg_hit(rs_de[k*REG_AW +: REG_AW], mdu_rd))
        forward[2*k +: 2] = 2'b01;
    end
  end

  assign mdu_waw  = rf_en_de && reg_hit(rd_de, mdu_rd);
  assign mw_busy  = ld_cnt > ONE;
  assign load_use = (ld_cnt == ONE) && ld_raw;
  assign mdu_pend = mdu_cnt > ONE;
  assign mdu_haz  = mdu_pend && (mdu_raw || mdu_waw || mdu_de);

  // A taken branch kills DE, so any stall it would have raised is moot.
  assign stall_de = (mw_busy || load_use || mdu_haz) && !br_taken;
  assign stall_if = stall_de;
  assign flush_de = br_taken || load_use || mdu_haz;
  assign issue    = valid_de && !stall_de && !br_taken;

  assign mdu_busy     = mdu_cnt != '0;
  assign mdu_wb_valid = mdu_cnt == ONE;
  assign mdu_wb_rd    = mdu_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt  <= '0;
      ld_rd   <= '0;
      mdu_cnt <= '0;
      mdu_rd  <= '0;
    end else begin
      if (issue && (sel_wb_de == SEL_LOAD)) begin
        ld_cnt <= LD_INIT;
        ld_rd  <= rd_de;
      end else begin
        ld_cnt <= cnt_dec(ld_cnt);
      end
      // Issue at mdu_cnt == 1 reloads the counter in the writeback cycle of the previous op.
      if (issue && mdu_de) begin
        mdu_cnt <= MDU_INIT;
        mdu_rd  <= rd_de;
      end else begin
        mdu_cnt <= cnt_dec(mdu_cnt);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_de) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_de) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: time-stamped behavioural model plus directed literal checks.
module tb_hazard_ctrl;
  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int LD_LAT  = 3;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      valid_de;
  logic [NUM_SRC*REG_AW-1:0] rs_de;
  logic [NUM_SRC-1:0]        rs_used_de;
  logic [REG_AW-1:0]         rd_de;
  logic                      rf_en_de;
  logic [1:0]                sel_wb_de;
  logic                      mdu_de;
  logic [REG_AW-1:0]         rd_mw;
  logic                      rf_en_mw;
  logic                      br_taken;
  logic [2*NUM_SRC-1:0]      forward;
  logic                      stall_if, stall_de, flush_de, mdu_busy, mdu_wb_valid;
  logic [REG_AW-1:0]         mdu_wb_rd;
  logic [CNT_W-1:0]          perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LD_LAT(LD_LAT), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_de(valid_de), .rs_de(rs_de), .rs_used_de(rs_used_de),
    .rd_de(rd_de), .rf_en_de(rf_en_de), .sel_wb_de(sel_wb_de), .mdu_de(mdu_de),
    .rd_mw(rd_mw), .rf_en_mw(rf_en_mw), .br_taken(br_taken), .forward(forward),
    .stall_if(stall_if), .stall_de(stall_de), .flush_de(flush_de), .mdu_busy(mdu_busy),
    .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Model state: cycle in which the last load / MDU op issued, plus their destinations.
  int          ld_t, mdu_t, last_wb;
  logic [4:0]  ld_rd_m, mdu_rd_m;
  int          perf_st, perf_fl;
  logic        e_stall, e_flush, e_issue;
  logic [3:0]  e_fwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic int perf_exp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic model_reset();
    ld_t = -100; mdu_t = -100; ld_rd_m = '0; mdu_rd_m = '0; perf_st = 0; perf_fl = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rfen,
                       input logic [1:0] selwb, input logic mdu, input logic [4:0] rdmw,
                       input logic rfenmw, input logic br);
    valid_de = v; rs_de = {r1, r0}; rs_used_de = used; rd_de = rd; rf_en_de = rfen;
    sel_wb_de = selwb; mdu_de = mdu; rd_mw = rdmw; rf_en_mw = rfenmw; br_taken = br;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Wait to the falling edge, derive every expected output from the model and compare.
  task automatic settle();
    int ld_rem, mdu_rem;
    bit ldep, mraw, waw, ld_hz, mdu_hz;
    logic [4:0] rs;
    @(negedge clk);
    ld_rem  = ld_t  + LD_LAT  + 1 - cyc; if (ld_rem  < 0) ld_rem  = 0;
    mdu_rem = mdu_t + MDU_LAT + 1 - cyc; if (mdu_rem < 0) mdu_rem = 0;
    ldep = 0; mraw = 0; e_fwd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs = rs_de[k*REG_AW +: REG_AW];
      if (rs_used_de[k] && hit(rs, ld_rd_m))  ldep = 1;
      if (rs_used_de[k] && hit(rs, mdu_rd_m)) mraw = 1;
      if (rf_en_mw && hit(rs, rd_mw))                e_fwd[2*k +: 2] = 2'b10;
      else if (mdu_rem == 1 && hit(rs, mdu_rd_m))    e_fwd[2*k +: 2] = 2'b01;
    end
    waw    = rf_en_de && hit(rd_de, mdu_rd_m);
    ld_hz  = (ld_rem == 1) && ldep;
    mdu_hz = (mdu_rem > 1) && (mraw || waw || mdu_de);
    e_stall = ((ld_rem > 1) || ld_hz || mdu_hz) && !br_taken;
    e_flush = br_taken || ld_hz || mdu_hz;
    e_issue = valid_de && !e_stall && !br_taken;
    chk("forward",      forward,        e_fwd);
    chk("stall_if",     stall_if,       e_stall);
    chk("stall_de",     stall_de,       e_stall);
    chk("flush_de",     flush_de,       e_flush);
    chk("mdu_busy",     mdu_busy,       mdu_rem != 0);
    chk("mdu_wb_valid", mdu_wb_valid,   mdu_rem == 1);
    chk("mdu_wb_rd",    mdu_wb_rd,      mdu_rd_m);
    chk("perf_stall",   perf_stall_cnt, perf_exp(perf_st));
    chk("perf_flush",   perf_flush_cnt, perf_exp(perf_fl));
    if (mdu_wb_valid === 1'b1) begin
      chk("wb_spacing", (cyc - last_wb) >= MDU_LAT, 1);
      last_wb = cyc;
    end
  endtask

  task automatic advance();
    if (rst) model_reset();
    else begin
      if (e_stall) perf_st++;
      if (e_flush) perf_fl++;
      if (e_issue) begin
        if (sel_wb_de == 2'b01) begin ld_t = cyc; ld_rd_m = rd_de; end
        if (mdu_de) begin mdu_t = cyc; mdu_rd_m = rd_de; end
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_fwd"},   forward, 0);
    chk({tag, "_sif"},   stall_if, 0);
    chk({tag, "_sde"},   stall_de, 0);
    chk({tag, "_fl"},    flush_de, 0);
    chk({tag, "_busy"},  mdu_busy, 0);
    chk({tag, "_wbv"},   mdu_wb_valid, 0);
    chk({tag, "_wbrd"},  mdu_wb_rd, 0);
    chk({tag, "_pst"},   perf_stall_cnt, 0);
    chk({tag, "_pfl"},   perf_flush_cnt, 0);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    last_wb = -1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Reset state
    settle(); all_zero("rst"); advance();

    // lw x5 then add x6,x5,x1 with LD_LAT=3
    drive(1, 10, 0, 2'b01, 5, 1, 2'b01, 0, 0, 0, 0);
    settle(); chk("lw_issue", stall_de, 0); advance();
    drive(1, 5, 1, 2'b11, 6, 1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle(); chk("lu_stall", stall_de, 1); chk("lu_flush", flush_de, i == 2); advance();
    end
    settle(); chk("lu_go", stall_de, 0); chk("lu_fwd0", forward[1:0], 2'b00); advance();
    idle_in(); settle(); advance();

    // mul x7 then add x8,x7,x2
    drive(1, 3, 4, 2'b11, 7, 1, 2'b00, 1, 0, 0, 0);
    settle(); chk("mul_issue", stall_de, 0); advance();
    drive(1, 7, 2, 2'b11, 8, 1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle(); chk("raw_stall", stall_de, 1); chk("raw_sif", stall_if, 1); chk("raw_flush", flush_de, 1);
      advance();
    end
    settle();
    chk("raw_go", stall_de, 0); chk("raw_fwd", forward[1:0], 2'b01);
    chk("raw_wbv", mdu_wb_valid, 1); chk("raw_wbrd", mdu_wb_rd, 7);
    advance();
    idle_in(); settle(); advance();

    // mul x7, mul x9 (structural), addi x9 (WAW)
    drive(1, 3, 4, 2'b11, 7, 1, 2'b00, 1, 0, 0, 0);
    settle(); advance();
    drive(1, 3, 4, 2'b11, 9, 1, 2'b00, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin settle(); chk("str_stall", stall_de, 1); advance(); end
    settle(); chk("str_go", stall_de, 0); chk("str_wbv", mdu_wb_valid, 1); advance();
    drive(1, 1, 0, 2'b01, 9, 1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin settle(); chk("waw_stall", stall_de, 1); advance(); end
    settle(); chk("waw_go", stall_de, 0); chk("waw_wbrd", mdu_wb_rd, 9); advance();
    idle_in(); settle(); advance();

    // branch during MDU RAW stall
    drive(1, 3, 4, 2'b11, 7, 1, 2'b00, 1, 0, 0, 0);
    settle(); advance();
    drive(1, 7, 2, 2'b11, 8, 1, 2'b00, 0, 0, 0, 0);
    settle(); chk("br_pre", stall_de, 1); advance();
    drive(1, 7, 2, 2'b11, 8, 1, 2'b00, 0, 0, 0, 1);
    settle(); chk("br_flush", flush_de, 1); chk("br_sif", stall_if, 0); chk("br_sde", stall_de, 0); advance();
    idle_in();
    settle(); chk("br_wait", mdu_wb_valid, 0); advance();
    settle(); chk("br_wbv", mdu_wb_valid, 1); chk("br_wbrd", mdu_wb_rd, 7); advance();

    // reset with mdu_cnt == 2
    drive(1, 3, 4, 2'b11, 7, 1, 2'b00, 1, 0, 0, 0);
    settle(); advance();
    idle_in();
    settle(); advance();
    settle(); advance();
    rst = 1'b1; settle(); advance();
    rst = 1'b0;
    settle(); all_zero("rst2"); advance();
    settle(); chk("rst2_nowb", mdu_wb_valid, 0); advance();

    // 21 stall cycles, 7 flush cycles from a reset baseline
    for (int r = 0; r < 7; r++) begin
      drive(1, 10, 0, 2'b01, 5, 1, 2'b01, 0, 0, 0, 0);
      settle(); advance();
      drive(1, 5, 1, 2'b11, 6, 1, 2'b00, 0, 0, 0, 0);
      repeat (4) begin settle(); advance(); end
    end
    idle_in();
    settle();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_sat", perf_stall_cnt, 15); chk("perf_fl7", perf_flush_cnt, 7);
`else
    chk("perf_off_s", perf_stall_cnt, 0); chk("perf_off_f", perf_flush_cnt, 0);
`endif
    advance();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
            ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00, $urandom_range(0, 4) == 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      settle(); advance();
    end
    rst = 1'b0;
    idle_in();
    repeat (6) begin settle(); advance(); end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
